io_interrupt_port: RTL and testbench

IO_INTERRUPT_PORT -- requirements
Module: io_interrupt_port

---
 rtl/io_interrupt_port_pkg.sv | 14 +
 rtl/rx_fifo.sv | 63 ++++++
 rtl/io_interrupt_port.sv | 111 +++++++++++
 tb/tb_io_interrupt_port.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/io_interrupt_port_pkg.sv
// Shared definitions for the IO interrupt port: FSM encoding and default sizing.
package io_interrupt_port_pkg;

    localparam int unsigned DefaultDepth   = 4;
    localparam int unsigned DefaultHoldoff = 1;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StPending = 2'd1,
        StService = 2'd2,
        StHold    = 2'd3
    } irq_state_e;

endpackage

// File: rtl/rx_fifo.sv
// Byte-wide receive FIFO; a push into a full FIFO succeeds only alongside a pop.
module rx_fifo #(
    parameter int unsigned Depth = 4,
    localparam int unsigned PtrW = $clog2(Depth),
    localparam int unsigned CntW = PtrW + 1
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            push_i,
    input  logic [7:0]      wdata_i,
    input  logic            pop_i,
    output logic [7:0]      rdata_o,
    output logic            full_o,
    output logic            empty_o,
    output logic [CntW-1:0] count_o
);

    logic [7:0]      mem_q [Depth];
    logic [PtrW-1:0] wptr_q, wptr_d;
    logic [PtrW-1:0] rptr_q, rptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic            push_ok, pop_ok;

    assign full_o  = (count_q == CntW'(Depth));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rptr_q];

    // Accept/pop qualification and pointer/count update; pointers wrap naturally.
    always_comb begin
        pop_ok  = pop_i && !empty_o;
        push_ok = push_i && (!full_o || pop_ok);
        wptr_d  = push_ok ? wptr_q + PtrW'(1) : wptr_q;
        rptr_d  = pop_ok ? rptr_q + PtrW'(1) : rptr_q;
        count_d = count_q;
        unique case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset; empty entries are masked by the consumer.
    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/io_interrupt_port.sv
// Interrupt-driven IO port: RX FIFO toward the processor, latched TX byte back out.
module io_interrupt_port
    import io_interrupt_port_pkg::*;
#(
    parameter int unsigned DEPTH   = DefaultDepth,
    parameter int unsigned HOLDOFF = DefaultHoldoff
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] ext_data,
    input  logic       ext_valid,
    output logic       ext_ready,
    output logic [7:0] data_in,
    output logic       interrupt,
    input  logic       int_ack,
    input  logic [7:0] data_out,
    input  logic       wr_en,
    output logic [7:0] port_out,
    output logic       port_out_strobe,
    output logic       overflow
);

    localparam int unsigned CntW = $clog2(DEPTH) + 1;

    irq_state_e      state_q, state_d;
    logic [2:0]      hold_q, hold_d;
    logic            irq_q, irq_d;
    logic            ovf_q, ovf_d;
    logic [7:0]      port_q;
    logic            strobe_q;
    logic [7:0]      head;
    logic            full, empty;
    logic [CntW-1:0] count;
    logic            ack_valid;

    rx_fifo #(
        .Depth (DEPTH)
    ) u_rx_fifo (
        .clk_i   (clk),
        .rst_ni  (reset),
        .push_i  (ext_valid),
        .wdata_i (ext_data),
        .pop_i   (ack_valid),
        .rdata_o (head),
        .full_o  (full),
        .empty_o (empty),
        .count_o (count)
    );

    assign ack_valid       = int_ack && (state_q == StService) && (count != '0);
    assign ext_ready       = !full;
    assign data_in         = empty ? 8'h00 : head;
    assign interrupt       = irq_q;
    assign overflow        = ovf_q;
    assign port_out        = port_q;
    assign port_out_strobe = strobe_q;

    // Interrupt FSM next state; interrupt is registered from the next state.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        unique case (state_q)
            StIdle:    if (count != '0) state_d = StPending;
            StPending: state_d = StService;
            StService: begin
                if (ack_valid) begin
                    state_d = StHold;
                    hold_d  = '0;
                end
            end
            StHold: begin
                if (hold_q == 3'(HOLDOFF - 1)) begin
                    state_d = (count != '0) ? StPending : StIdle;
                end else begin
                    hold_d = hold_q + 3'd1;
                end
            end
            default:   state_d = StIdle;
        endcase
        irq_d = (state_d == StPending) || (state_d == StService);
        // A dropped byte is one offered while full with no pop to make room.
        ovf_d = ovf_q || (ext_valid && full && !ack_valid);
    end

    // FSM, interrupt and sticky overflow registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            hold_q  <= '0;
            irq_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            irq_q   <= irq_d;
            ovf_q   <= ovf_d;
        end
    end

    // Processor write latch, independent of the receive path.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            port_q   <= 8'h00;
            strobe_q <= 1'b0;
        end else begin
            if (wr_en) port_q <= data_out;
            strobe_q <= wr_en;
        end
    end

endmodule

// File: tb/tb_io_interrupt_port.sv
// Self-checking bench for io_interrupt_port with a byte scoreboard of the RX FIFO.
module tb_io_interrupt_port;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] ext_data;
    logic       ext_valid;
    logic       ext_ready;
    logic [7:0] data_in;
    logic       interrupt;
    logic       int_ack;
    logic [7:0] data_out;
    logic       wr_en;
    logic [7:0] port_out;
    logic       port_out_strobe;
    logic       overflow;

    int unsigned n_pass  = 0;
    int unsigned n_total = 0;
    logic [7:0]  exp_q[$];
    logic        exp_ovf;

    io_interrupt_port #(
        .DEPTH   (4),
        .HOLDOFF (1)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .ext_data        (ext_data),
        .ext_valid       (ext_valid),
        .ext_ready       (ext_ready),
        .data_in         (data_in),
        .interrupt       (interrupt),
        .int_ack         (int_ack),
        .data_out        (data_out),
        .wr_en           (wr_en),
        .port_out        (port_out),
        .port_out_strobe (port_out_strobe),
        .overflow        (overflow)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b0;
        ext_data  = 8'h00;
        ext_valid = 1'b0;
        int_ack   = 1'b0;
        data_out  = 8'h00;
        wr_en     = 1'b0;
        exp_q.delete();
        exp_ovf   = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    // Offer one byte for one edge and update the scoreboard.
    task automatic push(input logic [7:0] b);
        ext_data  = b;
        ext_valid = 1'b1;
        if (exp_q.size() < 4) exp_q.push_back(b);
        else exp_ovf = 1'b1;
        tick();
        ext_valid = 1'b0;
    endtask

    // Returns once the FSM is in SERVICE: two consecutive high interrupt samples.
    task automatic wait_service(output bit timeout);
        bit prev;
        int n;
        timeout = 1'b0;
        prev    = (interrupt === 1'b1);
        n       = 0;
        while (1) begin
            tick();
            if (interrupt === 1'b1 && prev) break;
            prev = (interrupt === 1'b1);
            n++;
            if (n > 50) begin
                timeout = 1'b1;
                break;
            end
        end
    endtask

    // Waits for SERVICE, acks, reports the byte seen and interrupt just after the ack.
    task automatic serve(output logic [7:0] got, output bit timeout, output logic irq_after);
        wait_service(timeout);
        got       = data_in;
        irq_after = 1'bx;
        if (!timeout) begin
            int_ack = 1'b1;
            tick();
            int_ack   = 1'b0;
            irq_after = interrupt;
        end
    endtask

    task automatic test_reset();
        reset     = 1'b0;
        ext_data  = 8'hFF;
        ext_valid = 1'b0;
        int_ack   = 1'b0;
        data_out  = 8'hFF;
        wr_en     = 1'b0;
        #3;
        n_total++;
        if ({interrupt, overflow, port_out_strobe, ext_ready} !== 4'b0001)
            $display("FAIL reset_flags got int/ovf/strb/rdy=%b want 0001",
                     {interrupt, overflow, port_out_strobe, ext_ready});
        else n_pass++;
        n_total++;
        if (data_in !== 8'h00 || port_out !== 8'h00)
            $display("FAIL reset_data got data_in=%h port_out=%h want 00/00", data_in, port_out);
        else n_pass++;
        do_reset();
    endtask

    task automatic test_basic();
        logic [7:0] e;
        do_reset();
        push(8'hA5);
        n_total++;
        if (interrupt !== 1'b0) $display("FAIL basic_irq_early got %b want 0", interrupt);
        else n_pass++;
        tick();
        e = exp_q.pop_front();
        n_total++;
        if (interrupt !== 1'b1 || data_in !== e)
            $display("FAIL basic_irq_rise got irq=%b data=%h want 1/%h", interrupt, data_in, e);
        else n_pass++;
        tick();
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
        n_total++;
        if (interrupt !== 1'b0 || data_in !== 8'h00)
            $display("FAIL basic_after_ack got irq=%b data=%h want 0/00", interrupt, data_in);
        else n_pass++;
        tick();
        tick();
        n_total++;
        if (interrupt !== 1'b0 || ext_ready !== 1'b1)
            $display("FAIL basic_idle got irq=%b rdy=%b want 0/1", interrupt, ext_ready);
        else n_pass++;
    endtask

    task automatic test_overflow();
        logic [7:0] got, e;
        bit         to;
        logic       ia;
        do_reset();
        for (int i = 1; i <= 4; i++) push(8'(i));
        n_total++;
        if (ext_ready !== 1'b0) $display("FAIL ovf_full_ready got %b want 0", ext_ready);
        else n_pass++;
        push(8'h05);
        n_total++;
        if (overflow !== exp_ovf || data_in !== exp_q[0] || ext_ready !== 1'b0)
            $display("FAIL ovf_drop got ovf=%b data=%h rdy=%b want %b/%h/0",
                     overflow, data_in, ext_ready, exp_ovf, exp_q[0]);
        else n_pass++;
        for (int i = 0; i < 4; i++) begin
            serve(got, to, ia);
            e = exp_q.pop_front();
            n_total++;
            if (to || got !== e || ia !== 1'b0)
                $display("FAIL ovf_drain%0d got data=%h irq_after=%b timeout=%0d want %h/0/0",
                         i, got, ia, to, e);
            else n_pass++;
            if (i == 0) begin
                tick();
                n_total++;
                if (interrupt !== 1'b1)
                    $display("FAIL ovf_hold_len got irq=%b want 1 after one hold cycle",
                             interrupt);
                else n_pass++;
            end
        end
        tick();
        n_total++;
        if (data_in !== 8'h00 || overflow !== 1'b1 || interrupt !== 1'b0)
            $display("FAIL ovf_empty got data=%h ovf=%b irq=%b want 00/1/0",
                     data_in, overflow, interrupt);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [7:0] got, e;
        bit         to;
        logic       ia;
        do_reset();
        push(8'h11); push(8'h22); push(8'h33); push(8'h44);
        wait_service(to);
        e = exp_q.pop_front();
        n_total++;
        if (to || data_in !== e)
            $display("FAIL bb_head got %h timeout=%0d want %h", data_in, to, e);
        else n_pass++;
        // Same-cycle pop and push into the full FIFO.
        ext_data  = 8'h55;
        ext_valid = 1'b1;
        int_ack   = 1'b1;
        exp_q.push_back(8'h55);
        tick();
        ext_valid = 1'b0;
        int_ack   = 1'b0;
        n_total++;
        if (ext_ready !== 1'b0 || overflow !== 1'b0)
            $display("FAIL bb_count got rdy=%b ovf=%b want 0/0", ext_ready, overflow);
        else n_pass++;
        for (int i = 0; i < 4; i++) begin
            serve(got, to, ia);
            e = exp_q.pop_front();
            n_total++;
            if (to || got !== e)
                $display("FAIL bb_drain%0d got %h timeout=%0d want %h", i, got, to, e);
            else n_pass++;
        end
    endtask

    task automatic test_ack_ignored();
        logic [7:0] got, e;
        bit         to;
        logic       ia;
        do_reset();
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
        push(8'h77);
        // Hold ack through IDLE (with data) and PENDING.
        int_ack = 1'b1;
        tick();
        tick();
        int_ack = 1'b0;
        n_total++;
        if (interrupt !== 1'b1 || data_in !== exp_q[0])
            $display("FAIL ign_no_pop got irq=%b data=%h want 1/%h", interrupt, data_in, exp_q[0]);
        else n_pass++;
        serve(got, to, ia);
        e = exp_q.pop_front();
        n_total++;
        if (to || got !== e) $display("FAIL ign_serve got %h timeout=%0d want %h", got, to, e);
        else n_pass++;
        tick();
        n_total++;
        if (data_in !== 8'h00) $display("FAIL ign_empty got %h want 00", data_in);
        else n_pass++;
    endtask

    task automatic test_write();
        do_reset();
        wr_en    = 1'b1;
        data_out = 8'h3C;
        tick();
        n_total++;
        if (port_out !== 8'h3C || port_out_strobe !== 1'b1)
            $display("FAIL wr_first got %h/%b want 3c/1", port_out, port_out_strobe);
        else n_pass++;
        data_out = 8'hC3;
        tick();
        wr_en = 1'b0;
        n_total++;
        if (port_out !== 8'hC3 || port_out_strobe !== 1'b1)
            $display("FAIL wr_second got %h/%b want c3/1", port_out, port_out_strobe);
        else n_pass++;
        data_out = 8'h99;
        tick();
        n_total++;
        if (port_out !== 8'hC3 || port_out_strobe !== 1'b0 || interrupt !== 1'b0)
            $display("FAIL wr_idle got %h/%b irq=%b want c3/0/0",
                     port_out, port_out_strobe, interrupt);
        else n_pass++;
    endtask

    task automatic test_reset_mid_service();
        bit   to;
        logic seen;
        do_reset();
        push(8'hA1); push(8'hA2); push(8'hA3);
        wait_service(to);
        reset = 1'b0;
        #1;
        n_total++;
        if (to || interrupt !== 1'b0 || ext_ready !== 1'b1 || data_in !== 8'h00)
            $display("FAIL rst_async got irq=%b rdy=%b data=%h timeout=%0d want 0/1/00",
                     interrupt, ext_ready, data_in, to);
        else n_pass++;
        exp_q.delete();
        tick();
        reset = 1'b1;
        seen  = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (interrupt !== 1'b0) seen = 1'b1;
        end
        n_total++;
        if (seen !== 1'b0) $display("FAIL rst_quiet got irq seen=%b want 0", seen);
        else n_pass++;
        push(8'h5A);
        tick();
        n_total++;
        if (interrupt !== 1'b1 || data_in !== 8'h5A)
            $display("FAIL rst_new_push got irq=%b data=%h want 1/5a", interrupt, data_in);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_back_to_back();
        test_ack_ignored();
        test_write();
        test_reset_mid_service();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
